// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for an SRAM-style inst/data port.
// Word-addressed backing store, one-cycle registered reads, byte-lane writes,
// a zero-fill sequence after every reset, out-of-range detection and
// free-running access counters.
module sram_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] OOR_DATA   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        oor_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Byte span covered by the store, one bit wider than the address so the
  // comparison never wraps even for the largest legal ADDR_WIDTH.
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] fill_ptr;
  logic [ADDR_WIDTH-1:0] fill_ptr_next;
  logic                  fill_we;

  logic [31:0] mem [DEPTH];

  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  oor_acc;

  // Address decode: offset from the base, word index and range test.
  // Addresses below the base would wrap the subtraction, so they are
  // rejected by the explicit lower-bound compare.
  always_comb begin
    offset   = addr - BASE_ADDR;
    idx      = offset[ADDR_WIDTH+1:2];
    in_range = (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  end

  // Request classification; nothing is accepted while the store is filling.
  always_comb begin
    accept  = (state == READY) && en;
    rd_acc  = accept && in_range && (wen == 4'b0000);
    wr_acc  = accept && in_range && (wen != 4'b0000);
    oor_acc = accept && !in_range;
  end

  // Next-state logic: FILL walks every word once, then READY holds forever.
  always_comb begin
    state_next    = state;
    fill_ptr_next = fill_ptr;
    fill_we       = 1'b0;
    case (state)
      FILL: begin
        fill_we       = 1'b1;
        fill_ptr_next = fill_ptr + 1'b1;
        if (fill_ptr == LAST_IDX) begin
          state_next = READY;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next    = FILL;
        fill_ptr_next = '0;
      end
    endcase
  end

  // State and fill pointer registers; reset always restarts the fill at word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      fill_ptr <= '0;
    end else begin
      state    <= state_next;
      fill_ptr <= fill_ptr_next;
    end
  end

  assign busy = (state == FILL);

  // Backing store: zero-fill writes during FILL, lane-masked writes in READY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_we) begin
        mem[fill_ptr] <= '0;
      end else if (wr_acc) begin
        for (int lane = 0; lane < 4; lane++) begin
          if (wen[lane]) begin
            mem[idx][8*lane +: 8] <= wdata[8*lane +: 8];
          end
        end
      end
    end
  end

  // Registered read data: old word for any in-range access (read-before-write),
  // fixed pattern for out-of-range, otherwise hold the last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_acc || wr_acc) begin
      rdata <= mem[idx];
    end else if (oor_acc) begin
      rdata <= OOR_DATA;
    end
  end

  // Out-of-range flag pulses for exactly the cycle after the offending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      oor_err <= 1'b0;
    end else begin
      oor_err <= oor_acc;
    end
  end

  // Read counter: accepted in-range reads, wrapping silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
    end else if (rd_acc) begin
      rd_cnt <= rd_cnt + 32'd1;
    end
  end

  // Write counter: accepted in-range writes, wrapping silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt <= '0;
    end else if (wr_acc) begin
      wr_cnt <= wr_cnt + 32'd1;
    end
  end

endmodule
